spi_pred_link: RTL and testbench
================================

SPI_PRED_LINK -- requirements
Module: spi_pred_link

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning instruction-address bits per frame; legal range 2..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop stages on each of cs/sclk/mosi; legal range 2..3.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  SPI clock, asynchronous to clk; mode 0, data sampled on rising edge.
REQ-007 SHALL have port mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have port pred_in  input  1  predictor output for the current inst_addr.
REQ-009 SHALL have port miso  output  1  serial prediction readback.
REQ-010 SHALL have port inst_addr  output  ADDR_W  last received instruction address.
REQ-011 SHALL have port addr_valid  output  1  one-cycle pulse when inst_addr updates.
REQ-012 SHALL have port direction_ground_truth  output  1  branch outcome of last valid frame.
REQ-013 SHALL have port frame_valid  output  1  one-cycle pulse when a well-formed frame completes.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse when a malformed frame completes.

Function
REQ-015 SHALL pass cs, sclk and mosi through SYNC_STAGES flops; cs and sclk edges SHALL be detected on synchronised values against a one-cycle-delayed copy.
REQ-016 SHALL implement states IDLE and SHIFT; IDLE->SHIFT on synchronised cs falling edge; SHIFT->IDLE on synchronised cs rising edge.
REQ-017 On IDLE->SHIFT: bit counter cleared to 0; miso loaded with pred_in.
REQ-018 In SHIFT, each synchronised sclk rising edge SHALL shift synchronised mosi into an (ADDR_W+1)-bit shift register LSB-in, and increment the counter.
REQ-019 Counter SHALL saturate at ADDR_W+2; no wrap.
REQ-020 When the counter transitions ADDR_W-1 -> ADDR_W, inst_addr SHALL load the ADDR_W received bits (first bit = MSB) and addr_valid SHALL pulse on the following cycle.
REQ-021 miso SHALL be re-loaded from pred_in on the cycle after addr_valid, so the (ADDR_W+1)-th SCLK period reads back the prediction for the new address; miso otherwise holds.
REQ-022 On cs rising edge with counter == ADDR_W+1: direction_ground_truth SHALL take the last received bit; frame_valid SHALL pulse one cycle later.
REQ-023 On cs rising edge with counter != ADDR_W+1 (short, long or empty frame): frame_err SHALL pulse one cycle later; direction_ground_truth unchanged; inst_addr keeps any value loaded under REQ-020.
REQ-024 frame_valid and frame_err SHALL never assert in the same cycle; each SHALL pulse at most once per frame.
REQ-025 sclk rising edge coincident (same synchronised cycle) with cs rising edge SHALL NOT be counted.
REQ-026 sclk edges while IDLE SHALL be ignored.
REQ-027 cs falling edge coincident with an sclk rising edge SHALL enter SHIFT without sampling that bit.
REQ-028 Minimum clk/sclk ratio SHALL be 4; behaviour below that is undefined.

Reset
REQ-029 rst_n low SHALL force state IDLE, counter 0, shift register 0, inst_addr 0, direction_ground_truth 0, miso 0, addr_valid 0, frame_valid 0, frame_err 0, synchroniser flops 1 for cs and 0 for sclk/mosi.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a fresh cs falling edge and not resume the aborted frame even if cs is still low.

Verification
REQ-031 ADDR_W=16, frame 0xBEEF + direction 1 (17 sclk) -> addr_valid once, inst_addr=0xBEEF, then frame_valid once, direction_ground_truth=1.
REQ-032 pred_in=1 held during address 0x1234 -> miso=1 sampled on the 17th sclk rising edge by the master.
REQ-033 Frame of 10 sclk -> no addr_valid, frame_err once, inst_addr and direction_ground_truth unchanged.
REQ-034 Frame of 20 sclk with first 16 bits 0x00FF -> addr_valid once with inst_addr=0x00FF, frame_err once, direction unchanged.
REQ-035 rst_n pulsed after 8 sclk with cs held low, then 17 more sclk and cs high -> no frame_valid/frame_err; next full frame 0x0001+0 -> frame_valid, outputs 0x0001/0.
REQ-036 ADDR_W=8, back-to-back frames 0xA5+1 then 0x5A+0 with 2 clk cs-high gap -> two frame_valid pulses, final inst_addr=0x5A, direction=0.

Source files
------------

// File: rtl/spi_pred_link.sv
// SPI slave front end for a branch predictor.
// Receives an instruction address plus a branch-direction bit, publishes the
// address, and returns the predictor output on miso during the final bit.
module spi_pred_link #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              pred_in,
  output logic              miso,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              addr_valid,
  output logic              direction_ground_truth,
  output logic              frame_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(ADDR_W + 3);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(ADDR_W + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state_q, state_n;
  logic [SYNC_STAGES-1:0]   cs_sync, sclk_sync, mosi_sync;
  logic                     cs_d, sclk_d;
  logic                     cs_s, sclk_s, mosi_s;
  logic                     cs_fall, cs_rise, sclk_rise;
  logic [SYNC_STAGES:0]     flush_q;
  logic                     armed_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ADDR_W-1:0]        shreg_q;
  logic                     load_q;
  logic                     start, do_shift, end_ok, end_bad;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  // Synchronisers plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage capture its predecessor's old value.
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // Arm frame start only once cs has been seen high through a flushed
  // synchroniser, so a frame cut by reset is never resumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      flush_q <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      if (flush_q[SYNC_STAGES] && cs_s) armed_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state and per-cycle control strobes; cs rising wins over a coincident sclk edge.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_n  = state_q;
    start    = 1'b0;
    do_shift = 1'b0;
    end_ok   = 1'b0;
    end_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_n = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n = IDLE;
          if (cnt_q == CNT_FULL) end_ok  = 1'b1;
          else                   end_bad = 1'b1;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: bit counter, shift register, published results and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shift register is plain flops, so it is cleared along with the rest.
      cnt_q                  <= '0;
      shreg_q                <= '0;
      load_q                 <= 1'b0;
      inst_addr              <= '0;
      addr_valid             <= 1'b0;
      direction_ground_truth <= 1'b0;
      miso                   <= 1'b0;
      frame_valid            <= 1'b0;
      frame_err              <= 1'b0;
    end else begin
      load_q      <= do_shift && (cnt_q == CNT_ADDR_LAST);
      addr_valid  <= load_q;
      frame_valid <= end_ok;
      frame_err   <= end_bad;
      if (load_q) inst_addr <= shreg_q;
      if (start) begin
        cnt_q <= '0;
        miso  <= pred_in;
      end else if (addr_valid) begin
        miso  <= pred_in;
      end
      if (do_shift) begin
        shreg_q <= {shreg_q[ADDR_W-2:0], mosi_s};
        cnt_q   <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      if (end_ok) direction_ground_truth <= shreg_q[0];
    end
  end

endmodule

// File: tb/tb_spi_pred_link.sv
// Scoreboard bench for spi_pred_link: a 16-bit and an 8-bit instance.
module tb_spi_pred_link;

  localparam int HALF = 6;

  typedef enum int {EV_ADDR = 0, EV_VALID = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] addr;
    logic        dir;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cs16, sclk16, mosi16, pred16, miso16, av16, dir16, fv16, fe16;
  logic [15:0] addr16;
  logic        cs8, sclk8, mosi8, pred8, miso8, av8, dir8, fv8, fe8;
  logic [7:0]  addr8;

  ev_t         q16[$];
  ev_t         q8[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_addr16, exp_addr8;
  logic        exp_dir16, exp_dir8;
  logic        miso_samp[64];
  int          switch_at = 0;
  logic        pred_after = 1'b0;

  spi_pred_link #(.ADDR_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .cs(cs16), .sclk(sclk16), .mosi(mosi16),
    .pred_in(pred16), .miso(miso16), .inst_addr(addr16), .addr_valid(av16),
    .direction_ground_truth(dir16), .frame_valid(fv16), .frame_err(fe16)
  );

  spi_pred_link #(.ADDR_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .cs(cs8), .sclk(sclk8), .mosi(mosi8),
    .pred_in(pred8), .miso(miso8), .inst_addr(addr8), .addr_valid(av8),
    .direction_ground_truth(dir8), .frame_valid(fv8), .frame_err(fe8)
  );

  // Output pulses are popped against the scoreboard on the falling edge.
  always @(negedge clk) begin
    ev_t      e;
    ev_kind_t k;
    if (rst_n && (av16 || fv16 || fe16)) begin
      checks++;
      k = av16 ? EV_ADDR : (fv16 ? EV_VALID : EV_ERR);
      if (fv16 && fe16) begin
        errors++;
        $display("FAIL dut16_both_pulses: frame_valid=%b frame_err=%b, required one at most", fv16, fe16);
      end else if (q16.size() == 0) begin
        errors++;
        $display("FAIL dut16_unexpected_pulse: kind=%0d addr=%h dir=%b, required no pulse", k, addr16, dir16);
      end else begin
        e = q16.pop_front();
        if (k !== e.kind || addr16 !== e.addr || dir16 !== e.dir) begin
          errors++;
          $display("FAIL dut16_event: got kind=%0d addr=%h dir=%b, required kind=%0d addr=%h dir=%b",
                   k, addr16, dir16, e.kind, e.addr, e.dir);
        end
      end
    end
    if (rst_n && (av8 || fv8 || fe8)) begin
      checks++;
      k = av8 ? EV_ADDR : (fv8 ? EV_VALID : EV_ERR);
      if (fv8 && fe8) begin
        errors++;
        $display("FAIL dut8_both_pulses: frame_valid=%b frame_err=%b, required one at most", fv8, fe8);
      end else if (q8.size() == 0) begin
        errors++;
        $display("FAIL dut8_unexpected_pulse: kind=%0d addr=%h dir=%b, required no pulse", k, addr8, dir8);
      end else begin
        e = q8.pop_front();
        if (k !== e.kind || {8'h00, addr8} !== e.addr || dir8 !== e.dir) begin
          errors++;
          $display("FAIL dut8_event: got kind=%0d addr=%h dir=%b, required kind=%0d addr=%h dir=%b",
                   k, addr8, dir8, e.kind, e.addr, e.dir);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_pins(input bit sel, input logic c, input logic s, input logic m);
    if (sel) begin cs8 = c; sclk8 = s; mosi8 = m; end
    else     begin cs16 = c; sclk16 = s; mosi16 = m; end
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled as sclk rises.
  task automatic send_bits(input bit sel, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      set_pins(sel, 1'b0, 1'b0, v[n-1-i]);
      tick(HALF);
      set_pins(sel, 1'b0, 1'b1, v[n-1-i]);
      miso_samp[i] = sel ? miso8 : miso16;
      if (!sel && (i + 1 == switch_at)) pred16 = pred_after;
      tick(HALF);
    end
    set_pins(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input bit sel, input logic [63:0] v, input int n, input int gap);
    set_pins(sel, 1'b0, 1'b0, 1'b0);
    tick(HALF);
    send_bits(sel, v, n);
    tick(HALF);
    set_pins(sel, 1'b1, 1'b0, 1'b0);
    tick(gap);
  endtask

  // Reference model: decides which pulses a frame of n bits must produce.
  task automatic expect_frame(input bit sel, input logic [63:0] v, input int n);
    int          aw;
    logic [63:0] t;
    ev_t         e;
    aw = sel ? 8 : 16;
    if (n >= aw) begin
      t = v >> (n - aw);
      if (sel) exp_addr8 = {8'h00, t[7:0]};
      else     exp_addr16 = t[15:0];
      e.kind = EV_ADDR;
      e.addr = sel ? exp_addr8 : exp_addr16;
      e.dir  = sel ? exp_dir8 : exp_dir16;
      if (sel) q8.push_back(e); else q16.push_back(e);
    end
    if (n == aw + 1) begin
      if (sel) exp_dir8 = v[0]; else exp_dir16 = v[0];
      e.kind = EV_VALID;
    end else begin
      e.kind = EV_ERR;
    end
    e.addr = sel ? exp_addr8 : exp_addr16;
    e.dir  = sel ? exp_dir8 : exp_dir16;
    if (sel) q8.push_back(e); else q16.push_back(e);
  endtask

  task automatic check_drained(input string name);
    tick(20);
    checks++;
    if (q16.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses: pending dut16=%0d dut8=%0d, required 0", name, q16.size(), q8.size());
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({miso16, addr16, av16, dir16, fv16, fe16} !== 21'h0) begin
      errors++;
      $display("FAIL %s_dut16: miso=%b addr=%h av=%b dir=%b fv=%b fe=%b, required all 0",
               name, miso16, addr16, av16, dir16, fv16, fe16);
    end
    checks++;
    if ({miso8, addr8, av8, dir8, fv8, fe8} !== 13'h0) begin
      errors++;
      $display("FAIL %s_dut8: miso=%b addr=%h av=%b dir=%b fv=%b fe=%b, required all 0",
               name, miso8, addr8, av8, dir8, fv8, fe8);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_pins(1'b0, 1'b1, 1'b0, 1'b0);
    set_pins(1'b1, 1'b1, 1'b0, 1'b0);
    pred16 = 1'b1;
    pred8  = 1'b1;
    tick(5);
    check_zero("reset");
    exp_addr16 = '0; exp_dir16 = 1'b0;
    exp_addr8  = '0; exp_dir8  = 1'b0;
    rst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_good_frame;
    pred16     = 1'b0;
    switch_at  = 16;
    pred_after = 1'b1;
    expect_frame(1'b0, 64'h1_7DDF, 17);
    frame(1'b0, 64'h1_7DDF, 17, 12);
    switch_at = 0;
    check_drained("good_frame");
    checks++;
    if (miso_samp[0] !== 1'b0) begin
      errors++;
      $display("FAIL miso_first_bit: got %b, required 0", miso_samp[0]);
    end
    checks++;
    if (miso_samp[16] !== 1'b1) begin
      errors++;
      $display("FAIL miso_pred_bit: got %b, required 1", miso_samp[16]);
    end
    checks++;
    if (addr16 !== 16'hBEEF || dir16 !== 1'b1) begin
      errors++;
      $display("FAIL good_frame_outputs: addr=%h dir=%b, required addr=beef dir=1", addr16, dir16);
    end
  endtask

  task automatic test_short_frame;
    expect_frame(1'b0, 64'h3FF, 10);
    frame(1'b0, 64'h3FF, 10, 12);
    check_drained("short_frame");
    checks++;
    if (addr16 !== 16'hBEEF || dir16 !== 1'b1) begin
      errors++;
      $display("FAIL short_frame_hold: addr=%h dir=%b, required addr=beef dir=1", addr16, dir16);
    end
  endtask

  task automatic test_long_frame;
    expect_frame(1'b0, 64'h0_0FF0, 20);
    frame(1'b0, 64'h0_0FF0, 20, 12);
    check_drained("long_frame");
    checks++;
    if (addr16 !== 16'h00FF || dir16 !== 1'b1) begin
      errors++;
      $display("FAIL long_frame_outputs: addr=%h dir=%b, required addr=00ff dir=1", addr16, dir16);
    end
  endtask

  task automatic test_empty_frame;
    expect_frame(1'b0, 64'h0, 0);
    frame(1'b0, 64'h0, 0, 12);
    check_drained("empty_frame");
  endtask

  task automatic test_reset_mid_frame;
    pred16 = 1'b0;
    set_pins(1'b0, 1'b0, 1'b0, 1'b0);
    tick(HALF);
    send_bits(1'b0, 64'hA5, 8);
    rst_n = 1'b0;
    tick(3);
    check_zero("mid_reset");
    exp_addr16 = '0; exp_dir16 = 1'b0;
    exp_addr8  = '0; exp_dir8  = 1'b0;
    rst_n = 1'b1;
    send_bits(1'b0, 64'h1_FFFF, 17);
    tick(HALF);
    set_pins(1'b0, 1'b1, 1'b0, 1'b0);
    tick(12);
    check_drained("aborted_frame");
    expect_frame(1'b0, 64'h0_0002, 17);
    frame(1'b0, 64'h0_0002, 17, 12);
    check_drained("after_reset_frame");
    checks++;
    if (addr16 !== 16'h0001 || dir16 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_outputs: addr=%h dir=%b, required addr=0001 dir=0", addr16, dir16);
    end
  endtask

  task automatic test_back_to_back;
    expect_frame(1'b1, 64'h14B, 9);
    expect_frame(1'b1, 64'h0B4, 9);
    frame(1'b1, 64'h14B, 9, 2);
    frame(1'b1, 64'h0B4, 9, 12);
    check_drained("back_to_back");
    checks++;
    if (addr8 !== 8'h5A || dir8 !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_outputs: addr=%h dir=%b, required addr=5a dir=0", addr8, dir8);
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_short_frame;
    test_long_frame;
    test_empty_frame;
    test_reset_mid_frame;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
